// File: rtl/rf_pkg.sv
// Shared register-file constants for the write-port arbiter slice.
package rf_pkg;

   localparam int unsigned RF_DATA_W   = 16;
   localparam int unsigned RF_ADDR_W   = 3;
   localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

endpackage : rf_pkg

// File: rtl/rf_req_slot.sv
// One-entry holding slot for a single writeback requester.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid        - requester offers addr/data this cycle
//   in_ready_c      - slot can take a new entry (empty, or being drained this cycle)
//   in_addr/in_data - offered register address / data
//   grant           - arbiter drains this slot at the next edge
//   full/addr/data  - registered slot contents
module rf_req_slot
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready_c,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              grant,
   output logic              full,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // Ready depends only on registered state and the grant, never on in_valid.
   assign in_ready_c = !rst && (!full || grant);

   // A refill on the same edge as a drain keeps the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (in_valid && in_ready_c) begin
         full <= 1'b1;
         addr <= in_addr;
         data <= in_data;
      end else if (grant) begin
         full <= 1'b0;
      end
   end

endmodule : rf_req_slot

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one register-file write port.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data    - requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data    - requester B handshake and payload
//   wr_en/wr_addr/wr_data            - registered register-file write port
//   pend_mask                        - per-register pending-write flags (r0 never pending)
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [ADDR_W-1:0]      a_addr,
   input  logic [DATA_W-1:0]      a_data,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic [ADDR_W-1:0]      b_addr,
   input  logic [DATA_W-1:0]      b_data,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   output logic [(1<<ADDR_W)-1:0] pend_mask
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic              a_full, b_full;
   logic [ADDR_W-1:0] a_slot_addr, b_slot_addr;
   logic [DATA_W-1:0] a_slot_data, b_slot_data;
   logic              grant_a, grant_b;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_data;
   logic              last_b;   // B won the most recent tie

   rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (a_valid),
      .in_ready_c (a_ready),
      .in_addr    (a_addr),
      .in_data    (a_data),
      .grant      (grant_a),
      .full       (a_full),
      .addr       (a_slot_addr),
      .data       (a_slot_data)
   );

   rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_valid),
      .in_ready_c (b_ready),
      .in_addr    (b_addr),
      .in_data    (b_data),
      .grant      (grant_b),
      .full       (b_full),
      .addr       (b_slot_addr),
      .data       (b_slot_data)
   );

   // Round-robin grant: a lone full slot wins, a tie goes to whoever lost last.
   always_comb begin
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      gnt_addr = a_slot_addr;
      gnt_data = a_slot_data;
      if (a_full && (!b_full || last_b)) begin
         grant_a = 1'b1;
      end else if (b_full) begin
         grant_b  = 1'b1;
         gnt_addr = b_slot_addr;
         gnt_data = b_slot_data;
      end
   end

   // Tie pointer only moves when both slots contended.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b <= 1'b1;
      end else if (a_full && b_full) begin
         last_b <= grant_b;
      end
   end

   // Write-port register; r0 is hardwired zero so its writes are swallowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (grant_a || grant_b) begin
         wr_en   <= (gnt_addr != '0);
         wr_addr <= gnt_addr;
         wr_data <= gnt_data;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   // Pending flags from held slots and the write currently on the port.
   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if ((a_full && (a_slot_addr == ADDR_W'(i))) ||
             (b_full && (b_slot_addr == ADDR_W'(i))) ||
             (wr_en  && (wr_addr     == ADDR_W'(i)))) begin
            pend_mask[i] = 1'b1;
         end
      end
   end

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed stimulus pushes expected
// register writes; a negedge monitor pops and checks every wr_en cycle.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   a_valid, b_valid;
   logic                   a_ready, b_ready;
   logic [RF_ADDR_W-1:0]   a_addr, b_addr;
   logic [RF_DATA_W-1:0]   a_data, b_data;
   logic                   wr_en;
   logic [RF_ADDR_W-1:0]   wr_addr;
   logic [RF_DATA_W-1:0]   wr_data;
   logic [RF_NUM_REGS-1:0] pend_mask;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   rf_write_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every committed write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && wr_en) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t",
                     wr_addr, wr_data, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data) begin
               fails++;
               $display("FAIL write_order: got addr %0d data %h expected addr %0d data %h at %0t",
                        wr_addr, wr_data, e.addr, e.data, $time);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat on A and/or B across a single edge.
   task automatic drive(input logic va, input logic [RF_ADDR_W-1:0] aa, input logic [RF_DATA_W-1:0] da,
                        input logic vb, input logic [RF_ADDR_W-1:0] ab, input logic [RF_DATA_W-1:0] db);
      a_valid = va; a_addr = aa; a_data = da;
      b_valid = vb; b_addr = ab; b_data = db;
      if (va) check("a_ready_before_xfer", 32'(a_ready), 32'd1);
      if (vb) check("b_ready_before_xfer", 32'(b_ready), 32'd1);
      step();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic push(input logic [RF_ADDR_W-1:0] addr, input logic [RF_DATA_W-1:0] data);
      exp_t e;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      step();
      step();
      // Reset state
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'h0000);
      rst = 1'b0;
      #1;
      check("post_rst_pend", 32'(pend_mask), 32'h00);
      check("post_rst_a_ready", 32'(a_ready), 32'd1);

      // Single write, two-edge latency
      push(3'd3, 16'h07d8);
      drive(1'b1, 3'd3, 16'h07d8, 1'b0, 3'd0, 16'h0);
      check("single_pend_held", 32'(pend_mask), 32'h08);
      check("single_no_early_wr", 32'(wr_en), 32'd0);
      step();
      check("single_wr_en", 32'(wr_en), 32'd1);
      check("single_wr_addr", 32'(wr_addr), 32'd3);
      check("single_pend_on_port", 32'(pend_mask), 32'h08);
      step();
      check("single_wr_done", 32'(wr_en), 32'd0);
      check("single_pend_clear", 32'(pend_mask), 32'h00);
      step();

      // First tie after reset: A wins, then B
      push(3'd1, 16'h1245);
      push(3'd2, 16'h1874);
      drive(1'b1, 3'd1, 16'h1245, 1'b1, 3'd2, 16'h1874);
      check("tie1_pend", 32'(pend_mask), 32'h06);
      check("tie1_b_ready_blocked", 32'(b_ready), 32'd0);
      check("tie1_a_ready_granted", 32'(a_ready), 32'd1);
      step();
      step();
      step();
      // Second tie: B wins
      push(3'd2, 16'ha5a5);
      push(3'd1, 16'h5a5a);
      drive(1'b1, 3'd1, 16'h5a5a, 1'b1, 3'd2, 16'ha5a5);
      check("tie2_a_ready_blocked", 32'(a_ready), 32'd0);
      step();
      step();
      step();

      // Streaming from A alone: one write per cycle
      for (int k = 1; k <= 4; k++) push(3'd5, 16'(k));
      a_valid = 1'b1;
      a_addr  = 3'd5;
      for (int k = 1; k <= 4; k++) begin
         a_data = 16'(k);
         check("stream_a_ready", 32'(a_ready), 32'd1);
         step();
         if (k >= 2) check("stream_wr_en", 32'(wr_en), 32'd1);
      end
      a_valid = 1'b0;
      step();
      check("stream_last_wr_en", 32'(wr_en), 32'd1);
      check("stream_last_data", 32'(wr_data), 32'h0004);
      step();
      step();

      // r0 writes are consumed but suppressed
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h7777);
      check("r0_pend_slot", 32'(pend_mask), 32'h00);
      step();
      check("r0_wr_en", 32'(wr_en), 32'd0);
      check("r0_wr_data_loaded", 32'(wr_data), 32'h7777);
      check("r0_b_ready", 32'(b_ready), 32'd1);
      check("r0_pend_port", 32'(pend_mask), 32'h00);
      step();

      // Same-address pair: A first (B won the last tie), B's data lands last
      push(3'd4, 16'h8745);
      push(3'd4, 16'h1111);
      drive(1'b1, 3'd4, 16'h8745, 1'b1, 3'd4, 16'h1111);
      check("same_pend", 32'(pend_mask), 32'h10);
      step();
      check("same_first", 32'(wr_data), 32'h8745);
      step();
      check("same_final_addr", 32'(wr_addr), 32'd4);
      check("same_final_data", 32'(wr_data), 32'h1111);
      step();
      step();

      // Reset mid-operation with both slots full
      drive(1'b1, 3'd2, 16'hdead, 1'b1, 3'd3, 16'hbeef);
      rst = 1'b1;
      a_valid = 1'b1; a_addr = 3'd7; a_data = 16'hcafe;
      #1;
      check("midrst_a_ready", 32'(a_ready), 32'd0);
      check("midrst_b_ready", 32'(b_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_valid = 1'b0;
      check("midrst_pend", 32'(pend_mask), 32'h00);
      check("midrst_wr_en", 32'(wr_en), 32'd0);
      check("midrst_wr_data", 32'(wr_data), 32'h0000);
      for (int k = 0; k < 3; k++) begin
         step();
         check("midrst_no_write", 32'(wr_en), 32'd0);
      end

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule : tb_rf_write_arbiter

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports a_valid (input, 1), a_ready (output, 1), a_addr (input, ADDR_W) and a_data (input, DATA_W): requester A (ALU writeback).
REQ-006 SHALL have ports b_valid (input, 1), b_ready (output, 1), b_addr (input, ADDR_W) and b_data (input, DATA_W): requester B (load writeback).
REQ-007 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, DATA_W): single register-file write port, registered.
REQ-008 SHALL have port pend_mask  output  2**ADDR_W  per-register pending-write flags.

Function
REQ-009 SHALL hold each requester in a one-entry slot (full flag, addr, data); a transfer occurs at a rising edge when X_valid and X_ready are both high.
REQ-010 SHALL drive X_ready = !rst and (slot X empty or slot X granted this cycle), a function of registered state only, never of X_valid.
REQ-011 SHALL grant at most one full slot per cycle: if one slot is full, grant it; if both are full, grant the slot not granted last (round-robin pointer).
REQ-012 SHALL, at the edge ending a grant cycle, load wr_addr/wr_data from the granted slot, set wr_en = 1 if the granted addr != 0, and clear that slot unless it is refilled on the same edge.
REQ-013 SHALL, when the granted addr == 0, consume the slot normally but keep wr_en = 0 (r0 is hardwired zero).
REQ-014 SHALL drive wr_en = 0 in any cycle following a cycle with no grant; wr_addr/wr_data then hold their last value.
REQ-015 SHALL give a latency of 2 edges: a transfer at edge E0 with no contest makes wr_en high during the cycle after E0+1.
REQ-016 SHALL sustain 1 write per cycle from a single requester (accept and grant on the same edge) and 1 write per 2 cycles per requester under continuous contention.
REQ-017 SHALL update the round-robin pointer only on cycles where both slots were full.
REQ-018 SHALL set pend_mask[i] = 1 iff i != 0 and (a full slot holds addr i, or wr_en = 1 with wr_addr = i); pend_mask[0] is always 0.
REQ-019 SHALL, when both slots hold the same address, commit them in grant order, so the later-committed data is the final register value.

Reset
REQ-020 SHALL, on any edge with rst high, clear both slots, set wr_en = 0, wr_addr = 0, wr_data = 16'h0000, and set the pointer so that A wins the first tie.
REQ-021 SHALL hold a_ready and b_ready at 0 while rst is high and discard any in-flight slot contents when rst is asserted mid-operation.
REQ-022 SHALL make pend_mask = 0 in the cycle after a reset edge.

Structure
REQ-023 SHALL take DATA_W, ADDR_W and NUM_REGS (8) defaults from the shared package rf_pkg.
REQ-024 SHALL implement each holding slot as one sub-module rf_req_slot, instantiated twice; arbitration, the output register and pend_mask live in the top module.

Verification
REQ-025 SHALL cover single write: A sends addr 3 with 16'h07d8 -> wr_en=1, wr_addr=3, wr_data=16'h07d8 two edges later; pend_mask[3]=1 until that write cycle ends.
REQ-026 SHALL cover a tie: A (addr 1, 16'h1245) and B (addr 2, 16'h1874) transfer on the same edge after reset -> A commits first, then B on the next cycle; next tie -> B first.
REQ-027 SHALL cover streaming: A holds valid for 4 cycles (16'h0001..16'h0004, addr 5) with B idle -> a_ready stays 1 and four consecutive wr_en cycles occur in order.
REQ-028 SHALL cover r0 suppression: B writes addr 0, 16'h7777 -> slot consumed, b_ready returns, wr_en stays 0, pend_mask stays 0.
REQ-029 SHALL cover same-address ordering: A (addr 4, 16'h8745) and B (addr 4, 16'h1111) on one edge -> the final wr_data to addr 4 is 16'h1111.
REQ-030 SHALL cover reset mid-operation: both slots full, rst asserted for 1 cycle -> no wr_en afterwards, readies 0 during rst, pend_mask = 0 next cycle.
